// File: rtl/ysyx_lsu_mem_ctrl.sv
// Load/store unit: single-outstanding bus master with lane
// alignment, strobes, load extension and a one-cycle done pulse.
module ysyx_lsu_mem_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush_pipeline,
  input  logic            exu_ren,
  input  logic [XLEN-1:0] exu_raddr,
  input  logic [4:0]      exu_ralu,
  input  logic            exu_wen,
  input  logic [XLEN-1:0] exu_waddr,
  input  logic [4:0]      exu_walu,
  input  logic [XLEN-1:0] exu_wdata,
  output logic [XLEN-1:0] out_rdata,
  output logic            out_rvalid,
  output logic            out_wready,
  output logic            out_misalign,
  output logic            bus_valid,
  input  logic            bus_ready,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [XLEN/8-1:0] bus_wstrb,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_bvalid
);

  localparam int NB = XLEN / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic            st_q, st_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [NB-1:0]   wstrb_q, wstrb_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            squash_q, squash_d;
  logic            mis_q, mis_d;

  logic            w_mis;
  logic            r_mis;
  logic [XLEN-1:0] w_lane;
  logic [NB-1:0]   w_strb;
  logic [XLEN-1:0] r_sh;
  logic [XLEN-1:0] r_ext;
  logic            resp;

  logic unused_bits;
  assign unused_bits = ^{exu_ralu[4:3], exu_walu[4:2]};

  // misalignment: halfword on odd byte, word off a word boundary
  assign w_mis = (exu_walu[1:0] == 2'b01 && exu_waddr[0])
               | (exu_walu[1] && exu_waddr[1:0] != 2'b00);
  assign r_mis = (exu_ralu[1:0] == 2'b01 && exu_raddr[0])
               | (exu_ralu[1] && exu_raddr[1:0] != 2'b00);

  // store data shifted onto its byte lanes, plus strobes
  always_comb begin
    w_lane = '0;
    w_strb = '0;
    unique case (exu_walu[1:0])
      2'b00: begin
        w_lane = {{(XLEN-8){1'b0}}, exu_wdata[7:0]}
                 << {exu_waddr[1:0], 3'b000};
        w_strb = 4'b0001 << exu_waddr[1:0];
      end
      2'b01: begin
        w_lane = {{(XLEN-16){1'b0}}, exu_wdata[15:0]}
                 << {exu_waddr[1:0], 3'b000};
        w_strb = 4'b0011 << exu_waddr[1:0];
      end
      default: begin
        w_lane = exu_wdata;
        w_strb = 4'b1111;
      end
    endcase
  end

  // read word shifted down to bit 0, then sign/zero extended
  always_comb begin
    r_sh  = bus_rdata >> {addr_q[1:0], 3'b000};
    r_ext = r_sh;
    unique case (size_q)
      2'b00: r_ext = uns_q ? {{(XLEN-8){1'b0}}, r_sh[7:0]}
                           : {{(XLEN-8){r_sh[7]}}, r_sh[7:0]};
      2'b01: r_ext = uns_q ? {{(XLEN-16){1'b0}}, r_sh[15:0]}
                           : {{(XLEN-16){r_sh[15]}}, r_sh[15:0]};
      default: r_ext = r_sh;
    endcase
  end

  // next-state: accept op in IDLE, bus handshake, one-cycle RESP
  always_comb begin
    state_d  = state_q;
    st_d     = st_q;
    addr_d   = addr_q;
    size_d   = size_q;
    uns_d    = uns_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;
    squash_d = squash_q;
    mis_d    = mis_q;
    unique case (state_q)
      S_IDLE: begin
        squash_d = 1'b0;
        mis_d    = 1'b0;
        if (exu_wen) begin
          st_d    = 1'b1;
          addr_d  = exu_waddr;
          size_d  = exu_walu[1:0];
          uns_d   = 1'b0;
          wdata_d = w_lane;
          wstrb_d = w_strb;
          mis_d   = w_mis;
          state_d = w_mis ? S_RESP : S_REQ;
        end else if (exu_ren && !flush_pipeline) begin
          st_d    = 1'b0;
          addr_d  = exu_raddr;
          size_d  = exu_ralu[1:0];
          uns_d   = exu_ralu[2];
          wdata_d = '0;
          wstrb_d = '0;
          mis_d   = r_mis;
          if (r_mis) rdata_d = '0;
          state_d = r_mis ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (flush_pipeline && !st_q) squash_d = 1'b1;
        if (bus_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush_pipeline && !st_q) squash_d = 1'b1;
        if (!st_q && bus_rvalid) begin
          rdata_d = r_ext;
          state_d = S_RESP;
        end else if (st_q && bus_bvalid) begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers, synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      st_q     <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      squash_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      st_q     <= st_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      squash_q <= squash_d;
      mis_q    <= mis_d;
    end
  end

  assign resp         = (state_q == S_RESP);
  assign bus_valid    = (state_q == S_REQ);
  assign bus_we       = bus_valid & st_q;
  assign bus_addr     = addr_q;
  assign bus_wdata    = wdata_q;
  assign bus_wstrb    = wstrb_q;
  assign out_rdata    = rdata_q;
  assign out_rvalid   = resp & ~st_q & ~squash_q & ~flush_pipeline;
  assign out_wready   = resp & st_q;
  assign out_misalign = mis_q & (out_rvalid | out_wready);

endmodule

// File: tb/tb_ysyx_lsu_mem_ctrl.sv
// Bench for ysyx_lsu_mem_ctrl: byte-level memory model, bus
// responder with random latency, per-cycle output comparison.
module tb_ysyx_lsu_mem_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush_pipeline = 1'b0;
  logic        exu_ren = 1'b0;
  logic [31:0] exu_raddr = '0;
  logic [4:0]  exu_ralu = '0;
  logic        exu_wen = 1'b0;
  logic [31:0] exu_waddr = '0;
  logic [4:0]  exu_walu = '0;
  logic [31:0] exu_wdata = '0;
  logic [31:0] out_rdata;
  logic        out_rvalid, out_wready, out_misalign;
  logic        bus_valid, bus_we;
  logic        bus_ready, bus_rvalid, bus_bvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  ysyx_lsu_mem_ctrl #(.XLEN(32)) dut (
    .clock(clock), .reset(reset), .flush_pipeline(flush_pipeline),
    .exu_ren(exu_ren), .exu_raddr(exu_raddr), .exu_ralu(exu_ralu),
    .exu_wen(exu_wen), .exu_waddr(exu_waddr), .exu_walu(exu_walu),
    .exu_wdata(exu_wdata), .out_rdata(out_rdata),
    .out_rvalid(out_rvalid), .out_wready(out_wready),
    .out_misalign(out_misalign), .bus_valid(bus_valid),
    .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .bus_bvalid(bus_bvalid)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int nchk = 0;
  int npass = 0;

  task automatic chk(string nm, bit ok, logic [31:0] act,
                     logic [31:0] exp);
    nchk++;
    if (ok) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // reference memory (bytes) and responder memory (words)
  logic [7:0]  rmem [64];
  logic [31:0] bmem [16];

  task automatic poke(int off, logic [31:0] v);
    bmem[off/4] = v;
    for (int i = 0; i < 4; i++) rmem[off + i] = v[8*i +: 8];
  endtask

  // bus responder
  int fix_rdy = -1;
  int fix_rsp = -1;
  int nacc = 0;
  int nresp = 0;
  int resp_cyc = 0;

  initial begin
    bit          pend;
    bit          seen;
    bit          st_l;
    logic [5:0]  a_l;
    int          rdy_cnt;
    int          rsp_cnt;
    pend = 0; seen = 0; st_l = 0; a_l = '0;
    rdy_cnt = 0; rsp_cnt = 0;
    bus_ready = 0; bus_rvalid = 0; bus_bvalid = 0; bus_rdata = '0;
    forever begin
      @(posedge clock); #1;
      bus_rvalid = 0;
      bus_bvalid = 0;
      bus_ready  = 0;
      bus_rdata  = $urandom;
      if (pend) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          pend = 0;
          nresp++;
          resp_cyc = cyc;
          if (st_l) bus_bvalid = 1;
          else begin
            bus_rvalid = 1;
            bus_rdata  = bmem[a_l[5:2]];
          end
        end
      end else if (bus_valid) begin
        if (!seen) begin
          seen = 1;
          rdy_cnt = (fix_rdy >= 0) ? fix_rdy : int'($urandom_range(0, 3));
        end
        if (rdy_cnt == 0) bus_ready = 1;
        else rdy_cnt--;
      end
      @(negedge clock);
      if (bus_valid && bus_ready) begin
        pend = 1;
        seen = 0;
        nacc++;
        st_l = bus_we;
        a_l  = bus_addr[5:0];
        rsp_cnt = (fix_rsp >= 1) ? fix_rsp : int'($urandom_range(1, 3));
        if (bus_we)
          for (int l = 0; l < 4; l++)
            if (bus_wstrb[l])
              bmem[bus_addr[5:2]][8*l +: 8] = bus_wdata[8*l +: 8];
      end
    end
  end

  // expectations published by the driver
  bit          exp_bus = 0;
  bit          exp_we = 0;
  bit          exp_ld = 0;
  bit          exp_mis = 0;
  bit          exp_pend = 0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_wdata = '0;
  logic [3:0]  exp_wstrb = '0;
  logic [31:0] exp_rdata = '0;
  int          npulse0 = 0;
  int          bv0 = 0;
  int          nacc0 = 0;
  int          nresp0 = 0;
  int          req_cyc = 0;

  // observations from the compare process
  int          npulse = 0;
  int          pulse_cyc = 0;
  int          bv_cnt = 0;
  int          bv_start = 0;
  logic [31:0] got_rdata = '0;
  logic [31:0] last_wdata = '0;
  logic [3:0]  last_wstrb = '0;

  // per-cycle compare of bus request and done pulses
  initial begin
    bit prev_bv;
    prev_bv = 0;
    forever begin
      @(negedge clock);
      if (reset) prev_bv = 0;
      else begin
        if (bus_valid) begin
          bv_cnt++;
          if (!prev_bv) bv_start = cyc;
          last_wdata = bus_wdata;
          last_wstrb = bus_wstrb;
          if (!exp_bus) chk("bus_unexp", 0, bus_addr, 0);
          else if (exp_we)
            chk("bus_st", {bus_we, bus_addr, bus_wdata, bus_wstrb} ==
                {1'b1, exp_addr, exp_wdata, exp_wstrb},
                bus_wdata, exp_wdata);
          else
            chk("bus_ld", {bus_we, bus_addr} == {1'b0, exp_addr},
                bus_addr, exp_addr);
        end
        prev_bv = bus_valid;
        if (out_rvalid || out_wready) begin
          if (!exp_pend || npulse != npulse0)
            chk("pulse_unexp", 0, {30'b0, out_rvalid, out_wready}, 0);
          else begin
            chk("pulse_kind",
                {out_rvalid, out_wready, out_misalign} ==
                {exp_ld, ~exp_ld, exp_mis},
                {29'b0, out_rvalid, out_wready, out_misalign},
                {29'b0, exp_ld, ~exp_ld, exp_mis});
            if (exp_ld) chk("load_rdata", out_rdata == exp_rdata,
                            out_rdata, exp_rdata);
          end
          npulse++;
          pulse_cyc = cyc;
          got_rdata = out_rdata;
        end
      end
    end
  end

  // model: expected bus request and load result from byte memory
  task automatic set_exp(bit st, logic [4:0] alu, logic [31:0] a,
                         logic [31:0] d, bit sq);
    int          sz;
    logic [31:0] v;
    logic [31:0] w;
    logic [3:0]  s;
    sz = 1 << alu[1:0];
    exp_mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
    v = '0; w = '0; s = '0;
    for (int i = 0; i < sz; i++) begin
      v[8*i +: 8] = rmem[(int'(a[5:0]) + i) % 64];
      if (int'(a[1:0]) + i < 4) begin
        s[int'(a[1:0]) + i] = 1'b1;
        w[8*(int'(a[1:0]) + i) +: 8] = d[8*i +: 8];
      end
    end
    if (!alu[2] && sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!alu[2] && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
    exp_rdata = exp_mis ? 32'h0 : v;
    exp_wdata = w;
    exp_wstrb = s;
    exp_we    = st;
    exp_ld    = !st;
    exp_addr  = a;
    exp_bus   = !exp_mis;
    exp_pend  = !sq;
    npulse0   = npulse;
    bv0       = bv_cnt;
    nacc0     = nacc;
    nresp0    = nresp;
  endtask

  task automatic commit_store(logic [4:0] alu, logic [31:0] a,
                              logic [31:0] d);
    int sz;
    sz = 1 << alu[1:0];
    for (int i = 0; i < sz; i++)
      rmem[(int'(a[5:0]) + i) % 64] = d[8*i +: 8];
  endtask

  // run one op from a posedge+1 slot; flush_at = cycle after request
  task automatic run_op(bit st, logic [4:0] alu, logic [31:0] a,
                        logic [31:0] d, int flush_at, bit sq);
    int k;
    int tail;
    set_exp(st, alu, a, d, sq);
    if (st) begin
      exu_wen = 1; exu_waddr = a; exu_walu = alu; exu_wdata = d;
    end else begin
      exu_ren = 1; exu_raddr = a; exu_ralu = alu;
    end
    req_cyc = cyc;
    k = 0;
    tail = 0;
    forever begin
      @(posedge clock); #1;
      k++;
      flush_pipeline = (k == flush_at);
      if (flush_pipeline && !st) exu_ren = 0;
      @(negedge clock);
      if (!sq && npulse != npulse0) break;
      if (sq && (exp_mis || nresp != nresp0)) begin
        tail++;
        if (tail > 3) break;
      end
      if (k > 300) begin
        chk("timeout", 0, k, 0);
        break;
      end
    end
    @(posedge clock); #1;
    flush_pipeline = 0;
    exu_wen = 0;
    exu_ren = 0;
    chk("bus_count", (nacc - nacc0) == (exp_mis ? 0 : 1),
        nacc - nacc0, exp_mis ? 0 : 1);
    if (st && !exp_mis) commit_store(alu, a, d);
  endtask

  task automatic wait_pulse();
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (npulse != npulse0) return;
    end
    chk("pulse_timeout", 0, 0, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  localparam logic [31:0] BASE = 32'h8000_0000;

  initial begin
    int st_done;
    for (int wi = 0; wi < 16; wi++) poke(wi * 4, $urandom);
    poke(4, 32'hDEAD_BEEF);
    poke(0, 32'h8011_2233);

    repeat (3) @(posedge clock);
    #1;
    chk("reset_outs",
        {out_rdata, out_rvalid, out_wready, out_misalign, bus_valid,
         bus_we, bus_addr, bus_wdata, bus_wstrb} == '0, out_rdata, 0);
    reset = 0;
    @(posedge clock); #1;

    // zero-wait LW
    fix_rdy = 0; fix_rsp = 1;
    run_op(0, 5'b00010, BASE + 32'h4, 0, 0, 0);
    chk("t1_bv_lat", bv_start - req_cyc == 1, bv_start - req_cyc, 1);
    chk("t1_done_lat", pulse_cyc - req_cyc == 3, pulse_cyc - req_cyc, 3);
    chk("t1_rdata", got_rdata == 32'hDEAD_BEEF, got_rdata, 32'hDEAD_BEEF);

    // LB sign extension, LHU zero extension
    run_op(0, 5'b00000, BASE + 32'h3, 0, 0, 0);
    chk("t2_lb", got_rdata == 32'hFFFF_FF80, got_rdata, 32'hFFFF_FF80);
    run_op(0, 5'b00101, BASE + 32'h2, 0, 0, 0);
    chk("t2_lhu", got_rdata == 32'h0000_8011, got_rdata, 32'h0000_8011);

    // SB lane and strobe
    run_op(1, 5'b00000, BASE + 32'h1, 32'h0000_00AB, 0, 0);
    chk("t3_wstrb", last_wstrb == 4'b0010, last_wstrb, 4'b0010);
    chk("t3_wdata", last_wdata == 32'h0000_AB00, last_wdata, 32'h0000_AB00);
    chk("t3_wready_lat", pulse_cyc - resp_cyc == 1, pulse_cyc - resp_cyc, 1);

    // store and load requested together: store goes first
    set_exp(1, 5'b00010, BASE + 32'h10, 32'h1234_5678, 0);
    exu_wen = 1; exu_waddr = BASE + 32'h10;
    exu_walu = 5'b00010; exu_wdata = 32'h1234_5678;
    exu_ren = 1; exu_raddr = BASE + 32'h4; exu_ralu = 5'b00010;
    wait_pulse();
    st_done = pulse_cyc;
    @(posedge clock); #1;
    exu_wen = 0;
    commit_store(5'b00010, BASE + 32'h10, 32'h1234_5678);
    set_exp(0, 5'b00010, BASE + 32'h4, 0, 0);
    wait_pulse();
    chk("t4_order", bv_start > st_done, bv_start, st_done + 1);
    chk("t4_rdata", got_rdata == 32'hDEAD_BEEF, got_rdata, 32'hDEAD_BEEF);
    @(posedge clock); #1;
    exu_ren = 0;

    // reset while waiting for a read response
    fix_rdy = 0; fix_rsp = 3;
    set_exp(0, 5'b00010, BASE + 32'hC, 0, 0);
    exu_ren = 1; exu_raddr = BASE + 32'hC; exu_ralu = 5'b00010;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1; exu_ren = 0; exp_pend = 0; exp_bus = 0;
    @(posedge clock); #1;
    chk("rst_mid_outs",
        {out_rdata, out_rvalid, out_wready, out_misalign, bus_valid,
         bus_we, bus_addr, bus_wdata, bus_wstrb} == '0, out_rdata, 0);
    reset = 0;
    repeat (5) @(posedge clock);
    #1;
    chk("rst_no_pulse", npulse == npulse0, npulse - npulse0, 0);

    // stalled LW flushed while waiting for ready
    fix_rdy = 5; fix_rsp = 1;
    run_op(0, 5'b00010, BASE + 32'h8, 0, 2, 1);
    chk("t5_bv_held", bv_cnt - bv0 == 6, bv_cnt - bv0, 6);

    // misaligned accesses
    fix_rdy = 0; fix_rsp = 1;
    run_op(0, 5'b00001, 32'h0000_1001, 0, 0, 0);
    chk("t6_mis_lat", pulse_cyc - req_cyc == 1, pulse_cyc - req_cyc, 1);
    chk("t6_mis_rdata", got_rdata == 32'h0, got_rdata, 0);
    chk("t6_no_bus", bv_cnt == bv0, bv_cnt - bv0, 0);
    run_op(0, 5'b00010, BASE + 32'h6, 0, 1, 1);
    run_op(1, 5'b00001, BASE + 32'h3, 32'hCAFE_F00D, 0, 0);

    // flush has no effect on a store
    run_op(1, 5'b00010, BASE + 32'h20, 32'hA5A5_5A5A, 1, 0);

    // randomized traffic
    fix_rdy = -1; fix_rsp = -1;
    for (int n = 0; n < 200; n++) begin
      bit          st;
      logic [4:0]  alu;
      logic [31:0] a;
      int          sel;
      int          sz;
      int          fa;
      bit          sq;
      st = $urandom_range(0, 1);
      if (st) alu = 5'($urandom_range(0, 2));
      else begin
        sel = $urandom_range(0, 4);
        alu = 5'(sel < 3 ? sel : sel + 1);
      end
      sz = 1 << alu[1:0];
      a = BASE + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(sz) - 1);
      fa = 0; sq = 0;
      if ($urandom_range(0, 7) == 0) begin
        if (!st) begin
          if (!((sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00))) begin
            fa = $urandom_range(1, 2);
            sq = 1;
          end
        end else fa = 1;
      end
      run_op(st, alu, a, $urandom, fa, sq);
    end

    for (int wi = 0; wi < 16; wi++)
      chk("mem_word",
          bmem[wi] == {rmem[wi*4+3], rmem[wi*4+2], rmem[wi*4+1], rmem[wi*4]},
          bmem[wi],
          {rmem[wi*4+3], rmem[wi*4+2], rmem[wi*4+1], rmem[wi*4]});

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
